// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : PC owner, IM address/request, Instr/PC/PC+4 feed to decode with
//               one-delay-slot redirect and stall. Option: FETCH_IM_WAIT_EN. Rev 1.0
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC,
    input  logic        Request_Alt_PC,
    input  logic        STALL,
    output logic [31:0] Instr_address_2IM,
    output logic        IM_Req,
    input  logic [31:0] Instr1_fIM,
    input  logic        IM_Valid,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Instr_Valid_OUT
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SLOT_OWED = 2'd1,
        REDIR     = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_reg;
    logic [31:0] pend_pc;
    logic [31:0] pend_nxt;
    logic [31:0] alt_aligned;
    logic [31:0] target;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_plus4;
    logic        im_ok;
    logic        accept;
    logic        apply_redirect;
    logic        unused_bits;

`ifdef FETCH_IM_WAIT_EN
    assign im_ok       = IM_Valid;
    assign unused_bits = ^Alt_PC[1:0];
`else
    assign im_ok       = 1'b1;
    assign unused_bits = ^{Alt_PC[1:0], IM_Valid};
`endif

    // Every stored address is word aligned, so the fetch address needs no masking.
    assign alt_aligned       = {Alt_PC[31:2], 2'b00};
    assign target            = Request_Alt_PC ? alt_aligned : pend_pc;
    assign accept            = !STALL && im_ok;
    assign fetch_addr        = apply_redirect ? target : pc_reg;
    assign fetch_plus4       = fetch_addr + 32'd4;
    assign Instr_address_2IM = fetch_addr;
    assign IM_Req            = !STALL;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= RUN;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_nxt;
        end
    end

    // A fetch accepted in the same cycle the slot becomes owed is the delay slot itself.
    always_comb begin
        state_nxt      = state;
        pend_nxt       = pend_pc;
        apply_redirect = 1'b0;
        if (Request_Alt_PC) begin
            pend_nxt = alt_aligned;
        end
        case (state)
            RUN: begin
                if (Request_Alt_PC) begin
                    if (STALL) begin
                        state_nxt = Instr_Valid_OUT ? REDIR : SLOT_OWED;
                    end else if (Instr_Valid_OUT) begin
                        apply_redirect = 1'b1;
                        if (!accept) begin
                            state_nxt = REDIR;
                        end
                    end else begin
                        state_nxt = accept ? REDIR : SLOT_OWED;
                    end
                end
            end
            SLOT_OWED: begin
                if (accept) begin
                    state_nxt = REDIR;
                end
            end
            REDIR: begin
                apply_redirect = 1'b1;
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_reg             <= RESET_PC_ALIGNED;
            Instr1_OUT         <= NOP_INSTR;
            Instr_PC_OUT       <= '0;
            Instr_PC_Plus4_OUT <= '0;
            Instr_Valid_OUT    <= 1'b0;
        end else if (accept) begin
            pc_reg             <= fetch_plus4;
            Instr1_OUT         <= Instr1_fIM;
            Instr_PC_OUT       <= fetch_addr;
            Instr_PC_Plus4_OUT <= fetch_plus4;
            Instr_Valid_OUT    <= 1'b1;
        end else if (!STALL) begin
            Instr1_OUT      <= NOP_INSTR;
            Instr_Valid_OUT <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// tb_instr_fetch : random + directed stimulus against a pending-redirect reference model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam logic [31:0] NOP      = 32'h00000000;
`ifdef FETCH_IM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] Alt_PC = '0;
    logic        Request_Alt_PC = 1'b0;
    logic        STALL = 1'b0;
    logic [31:0] Instr_address_2IM;
    logic        IM_Req;
    logic [31:0] Instr1_fIM;
    logic        IM_Valid = 1'b1;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Instr_Valid_OUT;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Alt_PC            (Alt_PC),
        .Request_Alt_PC    (Request_Alt_PC),
        .STALL             (STALL),
        .Instr_address_2IM (Instr_address_2IM),
        .IM_Req            (IM_Req),
        .Instr1_fIM        (Instr1_fIM),
        .IM_Valid          (IM_Valid),
        .Instr1_OUT        (Instr1_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
        .Instr_Valid_OUT   (Instr_Valid_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign Instr1_fIM = mem_word(Instr_address_2IM);

    // Reference model: program-order view of what decode should see.
    logic [31:0] m_next, m_tgt, m_instr, m_pc, m_p4;
    bit          m_pend, m_slot, m_valid;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_regs();
        check_eq("instr_out", Instr1_OUT, m_instr);
        check_eq("pc_out", Instr_PC_OUT, m_pc);
        check_eq("pc_plus4_out", Instr_PC_Plus4_OUT, m_p4);
        check_eq("valid_out", {31'd0, Instr_Valid_OUT}, {31'd0, m_valid});
    endtask

    task automatic model_reset();
        m_next  = RESET_PC;
        m_tgt   = '0;
        m_pend  = 1'b0;
        m_slot  = 1'b0;
        m_instr = NOP;
        m_pc    = '0;
        m_p4    = '0;
        m_valid = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; effect must be visible before any edge.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        STALL          = 1'b0;
        Request_Alt_PC = 1'b0;
        IM_Valid       = 1'b1;
        RESET          = 1'b0;
        model_reset();
        #1;
        check_eq("reset_addr", Instr_address_2IM, RESET_PC);
        check_regs();
        @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    task automatic step(input bit stall, input bit req, input logic [31:0] alt, input bit imv);
        bit          p, sd, acc;
        logic [31:0] t, addr;
        @(negedge CLK);
        STALL          = stall;
        Request_Alt_PC = req;
        Alt_PC         = alt;
        IM_Valid       = imv;
        p  = m_pend;
        sd = m_slot;
        t  = m_tgt;
        if (req) begin
            if (!p) begin
                p  = 1'b1;
                sd = m_valid;   // delay slot already in decode?
            end
            t = {alt[31:2], 2'b00};
        end
        addr = (p && sd) ? t : m_next;
        acc  = !stall && (imv || !WAIT_EN);
        #1;
        check_regs();
        check_eq("im_req", {31'd0, IM_Req}, {31'd0, !stall});
        if (!stall) check_eq("fetch_addr", Instr_address_2IM, addr);
        @(posedge CLK);
        m_tgt  = t;
        m_pend = p;
        m_slot = sd;
        if (acc) begin
            m_instr = mem_word(addr);
            m_pc    = addr;
            m_p4    = addr + 32'd4;
            m_valid = 1'b1;
            m_next  = addr + 32'd4;
            if (p && sd) m_pend = 1'b0;
            else if (p) m_slot = 1'b1;
        end else if (!stall) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
    endtask

    initial begin
        do_reset();

        // T1: first fetch from reset vector
        step(0, 0, '0, 1);
        #1;
        check_eq("t1_pc", Instr_PC_OUT, 32'hBFC00000);
        check_eq("t1_plus4", Instr_PC_Plus4_OUT, 32'hBFC00004);
        step(0, 0, '0, 1);

        // T2: branch redirect with delay slot already in decode
        step(0, 1, 32'hBFC00100, 1);
        step(0, 0, '0, 1);
        check_eq("t2_target_pc", Instr_PC_OUT, 32'hBFC00100);
        step(0, 0, '0, 1);

        // T3: redirect held during a three-cycle stall
        step(1, 1, 32'h00400020, 1);
        step(1, 1, 32'h00400020, 1);
        step(1, 1, 32'h00400020, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        check_eq("t3_target_pc", Instr_PC_OUT, 32'h00400020);

        // T4/T5: wait bubbles and a redirect that arrives behind a bubble
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        step(0, 1, 32'h00400080, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // T6: wrap past the top of the address space
        step(0, 1, 32'hFFFFFFFD, 1);
        step(0, 0, '0, 1);
        check_eq("t6_wrap_pc", Instr_PC_OUT, 32'hFFFFFFFC);
        check_eq("t6_wrap_plus4", Instr_PC_Plus4_OUT, 32'h00000000);
        step(0, 0, '0, 1);
        step(1, 1, 32'h00400040, 1);
        do_reset();

        for (int i = 0; i < 4000; i++) begin
            bit          s, r, v;
            logic [31:0] a;
            s = ($urandom % 5) == 0;
            r = ($urandom % 6) == 0;
            v = ($urandom % 4) != 0;
            a = (($urandom % 8) == 0) ? 32'hFFFFFFFC : $urandom;
            step(s, r, a, v);
            if ((i % 700) == 699) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
